// File: rtl/ov7670_config_seq.sv
// rtl/ov7670_config_seq.sv - OV7670 register initialisation sequencer
//
// Walks the config ROM from address 0 and turns each 16-bit entry into an
// SCCB write, a fixed delay (16'hFFF0) or end-of-table (16'hFFFF).
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   start              one-cycle pulse, starts a sequence when not busy
//   busy / done / err  in progress / finished / aborted on NACK (held to next start)
//   rom_addr, rom_dout config ROM address and 1-cycle registered read data
//   cmd_valid/ready    SCCB write request handshake
//   cmd_id/reg/data    write payload (device ID, register, value)
//   sccb_done/nack     transaction complete pulse, NACK flag valid with it

module ov7670_config_seq #(
    parameter int unsigned DELAY_CYCLES = 240000,
    parameter int unsigned MAX_RETRY    = 2,
    parameter logic [7:0]  SCCB_ID      = 8'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_id,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        sccb_done,
    input  logic        sccb_nack
);

    // Counter only ever holds DELAY_CYCLES-1 down to 0.
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT,
        S_DELAY,
        S_FIN
    } state_t;

    state_t           state;
    logic [RTY_W-1:0] retry;
    logic [CNT_W-1:0] dly_cnt;

    assign cmd_id = SCCB_ID;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rom_addr  <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_reg   <= 8'd0;
            cmd_data  <= 8'd0;
            retry     <= '0;
            dly_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        rom_addr <= 8'd0;
                        retry    <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                // ROM registers rom_addr on this edge; data is valid in DECODE.
                S_FETCH: state <= S_DECODE;

                S_DECODE: begin
                    if (rom_dout == MARK_END) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else if (rom_dout == MARK_DELAY) begin
                        dly_cnt <= DLY_LOAD;
                        state   <= S_DELAY;
                    end else if (rom_dout[15:8] == 8'hFF) begin
                        // Other 8'hFFxx words are reserved markers: skip them.
                        if (rom_addr == 8'hFF) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        cmd_reg   <= rom_dout[15:8];
                        cmd_data  <= rom_dout[7:0];
                        cmd_valid <= 1'b1;
                        retry     <= '0;
                        state     <= S_SEND;
                    end
                end

                // Payload registers are untouched here, so they stay stable
                // for as long as the master stalls.
                S_SEND: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            if (rom_addr == 8'hFF) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                rom_addr <= rom_addr + 8'd1;
                                state    <= S_FETCH;
                            end
                        end else if (retry < RTY_MAX) begin
                            retry     <= retry + RTY_W'(1);
                            cmd_valid <= 1'b1;
                            state     <= S_SEND;
                        end else begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end

                // Counter visits DELAY_CYCLES-1 .. 0, one cycle each.
                S_DELAY: begin
                    if (dly_cnt == '0) begin
                        if (rom_addr == 8'hFF) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb/tb_ov7670_config_seq.sv - self-checking bench for ov7670_config_seq

module tb_ov7670_config_seq;

    localparam int D  = 5;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_id, cmd_reg, cmd_data;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;

    ov7670_config_seq #(.DELAY_CYCLES(D), .MAX_RETRY(MR), .SCCB_ID(8'h42)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [256];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] log_q[$];
    logic [23:0] exp_q[$];
    int          rise_t[$];
    int          done_t[$];
    int          nack_plan[$];
    int          wi = 0, nack_cnt = 0;
    int          rdy_dly = 0, done_dly = 1;
    int          stab_viol = 0, stab_checks = 0;
    bit          exp_err;
    int          exp_addr;

    // SCCB master model plus monitor, acting on the falling edge.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_id, prev_reg, prev_data;
        int         wait_cnt, done_cnt;
        bit         hs;
        prev_valid = 0; wait_cnt = 0; done_cnt = 0;
        prev_id = 0; prev_reg = 0; prev_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_ready = 0; sccb_done = 0; sccb_nack = 0;
                prev_valid = 0; wait_cnt = 0; done_cnt = 0;
            end else begin
                hs = prev_valid && cmd_ready;
                if (hs) log_q.push_back({prev_id, prev_reg, prev_data});
                else if (prev_valid) begin
                    stab_checks++;
                    if (!(cmd_valid && cmd_reg == prev_reg && cmd_data == prev_data))
                        stab_viol++;
                end
                if (cmd_valid && !prev_valid) rise_t.push_back(cyc);
                sccb_done = 0; sccb_nack = 0;
                if (hs) begin
                    cmd_ready = 0; wait_cnt = 0; done_cnt = done_dly;
                end else if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        sccb_done = 1;
                        done_t.push_back(cyc + 1);
                        if (wi < nack_plan.size() && nack_cnt < nack_plan[wi]) begin
                            sccb_nack = 1; nack_cnt++;
                        end else begin
                            wi++; nack_cnt = 0;
                        end
                    end
                end else if (cmd_valid) begin
                    if (wait_cnt >= rdy_dly) cmd_ready = 1;
                    else wait_cnt++;
                end else begin
                    cmd_ready = 0; wait_cnt = 0;
                end
                prev_valid = cmd_valid; prev_id = cmd_id;
                prev_reg = cmd_reg; prev_data = cmd_data;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        log_q.delete(); rise_t.delete(); done_t.delete();
        wi = 0; nack_cnt = 0; stab_viol = 0; stab_checks = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(1); start = 0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 20000) begin step(1); t++; end
        check({tag, " timeout"}, 32'(t < 20000), 32'd1);
    endtask

    // Reference: walk the table by its rules and list every write attempt.
    task automatic model();
        int w, n;
        exp_q.delete(); exp_err = 0; exp_addr = 255; w = 0;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin exp_addr = a; break; end
            if (rom[a][15:8] == 8'hFF) continue;
            n = (w < nack_plan.size()) ? nack_plan[w] : 0;
            w++;
            if (n > MR) begin
                repeat (MR + 1) exp_q.push_back({8'h42, rom[a]});
                exp_err = 1; exp_addr = a;
                break;
            end
            repeat (n + 1) exp_q.push_back({8'h42, rom[a]});
        end
    endtask

    task automatic compare(input string tag);
        model();
        check({tag, " count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check({tag, " write"}, log_q[i], exp_q[i]);
        check({tag, " err"}, err, exp_err);
        check({tag, " done"}, done, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " addr"}, rom_addr, exp_addr);
        check({tag, " stable"}, stab_viol, 0);
    endtask

    task automatic load_fill(input logic [15:0] v);
        for (int a = 0; a < 256; a++) rom[a] = v;
    endtask

    task automatic load_t1();
        load_fill(16'hFFFF);
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
    endtask

    initial begin
        int t, len, r, nw;
        load_fill(16'hFFFF);

        // Reset values
        step(3);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst addr", rom_addr, 0);
        check("rst valid", cmd_valid, 0);
        check("rst payload", {cmd_reg, cmd_data}, 0);
        rst = 0;
        step(2);
        check("idle busy", busy, 0);

        // Directed table with a delay entry
        load_t1(); nack_plan.delete(); rdy_dly = 1; done_dly = 3;
        clear_logs();
        pulse_start();
        wait_done("t1");
        compare("t1");
        if (done_t.size() >= 1 && rise_t.size() >= 2)
            check("t1 delay gap", rise_t[1] - done_t[0], 2 * 2 + D);
        else
            check("t1 events", 32'(done_t.size() >= 1 && rise_t.size() >= 2), 1);

        // Empty table: done on the 3rd edge
        load_fill(16'hFFFF); clear_logs();
        pulse_start();
        check("empty e1 done", done, 0);
        check("empty e1 busy", busy, 1);
        step(1);
        check("empty e2 done", done, 0);
        step(1);
        check("empty e3 done", done, 1);
        check("empty e3 busy", busy, 0);
        step(3);
        check("empty no cmd", log_q.size() + rise_t.size(), 0);

        // Stalled ready
        load_fill(16'hFFFF); rom[0] = 16'h3C5A; rdy_dly = 10; done_dly = 2;
        clear_logs();
        pulse_start();
        wait_done("stall");
        compare("stall");
        check("stall held", 32'(stab_checks >= 10), 1);

        // NACK twice then ACK
        load_fill(16'hFFFF); rom[0] = 16'h0A55; rom[1] = 16'h0B66;
        rdy_dly = 0; done_dly = 2;
        nack_plan = '{2, 0};
        clear_logs();
        pulse_start();
        wait_done("nack2");
        compare("nack2");

        // NACK three times: abort
        nack_plan = '{3, 0};
        clear_logs();
        pulse_start();
        wait_done("nack3");
        compare("nack3");
        step(5);
        check("nack3 quiet", log_q.size(), MR + 1);

        // No end marker: 256 writes, no wrap
        load_fill(16'h0101); nack_plan.delete(); rdy_dly = 0; done_dly = 1;
        clear_logs();
        pulse_start();
        wait_done("full");
        compare("full");
        step(4);
        check("full no wrap", rom_addr, 8'hFF);

        // Reset while waiting for completion
        load_t1(); rdy_dly = 0; done_dly = 30;
        clear_logs();
        pulse_start();
        t = 0;
        while (log_q.size() == 0 && t < 200) begin step(1); t++; end
        check("rstw reached", log_q.size(), 1);
        step(2);
        rst = 1; step(1);
        check("rstw busy", busy, 0);
        check("rstw done", done, 0);
        check("rstw valid", cmd_valid, 0);
        check("rstw addr", rom_addr, 0);
        check("rstw payload", {cmd_reg, cmd_data}, 0);
        rst = 0; step(40);
        check("rstw idle", {busy, cmd_valid}, 0);
        check("rstw no more", log_q.size(), 1);

        // Start during busy is ignored
        done_dly = 3; rdy_dly = 1;
        clear_logs();
        pulse_start();
        step(8);
        pulse_start();
        step(3);
        pulse_start();
        wait_done("rebusy");
        compare("rebusy");

        // Start after done clears done and replays
        clear_logs();
        pulse_start();
        check("replay done clr", done, 0);
        check("replay busy", busy, 1);
        wait_done("replay");
        compare("replay");

        // Randomised tables, latencies and NACK patterns
        for (int it = 0; it < 20; it++) begin
            load_fill(16'hFFFF);
            len = $urandom_range(1, 20);
            nw = 0;
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 5);
                if (r == 0) rom[i] = 16'hFFF0;
                else begin
                    rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
                    nw++;
                end
            end
            nack_plan.delete();
            for (int i = 0; i < nw; i++) begin
                r = $urandom_range(0, 19);
                nack_plan.push_back(r < 13 ? 0 : r < 16 ? 1 : r < 19 ? 2 : 3);
            end
            rdy_dly = $urandom_range(0, 3);
            done_dly = $urandom_range(1, 4);
            clear_logs();
            pulse_start();
            wait_done("rand");
            compare("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
